// File: rtl/ddr_rd_checker_if.sv
// MIG application read-data bus as seen by a read-back checker.
//   app_rd_data        : read data, one beat per valid cycle
//   app_rd_data_valid  : beat qualifier
//   app_rd_data_end    : end-of-burst marker
// master drives the bus (MIG or a stimulus source); slave observes it.
interface ddr_rd_checker_if #(
  parameter int APP_DATA_WIDTH = 128
);
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;

  modport master (
    output app_rd_data,
    output app_rd_data_valid,
    output app_rd_data_end
  );

  modport slave (
    input app_rd_data,
    input app_rd_data_valid,
    input app_rd_data_end
  );
endinterface

// File: rtl/ddr_rd_checker.sv
// Read-back checker for a DDR memory test. A start pulse arms a run of
// num_beats beats beginning at base_addr. Each valid beat is compared against
// the pattern {zeros, exp_addr[7:0]}, where exp_addr advances by ADDR_STEP
// per beat. The run ends when all beats arrive or when TIMEOUT idle cycles
// pass between beats.
// Ports:
//   ui_clk, ui_rst   : clock, asynchronous active-high reset
//   start            : one-cycle pulse arming a run (ignored while busy)
//   base_addr        : first expected address, sampled on start
//   num_beats        : beats expected, sampled on start
//   rd               : MIG read-data bus (slave modport)
//   busy             : run in progress
//   done / pass      : run finished / finished clean (pass qualified by done)
//   timeout          : run ended by the idle timeout
//   err_cnt          : mismatching beats (saturating)
//   beat_cnt         : beats received in the current/last run
//   first_err_addr   : expected address of the first mismatch
//   first_err_data   : low byte of the data of the first mismatch
//   stray_beat       : sticky, valid seen while no run was active
module ddr_rd_checker #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int ADDR_STEP      = 8,
  parameter int CNT_WIDTH      = 12,
  parameter int TIMEOUT        = 4096
) (
  input  logic                  ui_clk,
  input  logic                  ui_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  ddr_rd_checker_if.slave       rd,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [7:0]            first_err_data,
  output logic                  stray_beat
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     exp_addr;
  logic [CNT_WIDTH-1:0]      num_r;
  logic [IDLE_W-1:0]         idle_cnt;
  logic [APP_DATA_WIDTH-1:0] exp_data;
  logic                      accept, beat, last_beat, expire, mismatch;
  logic [CNT_WIDTH-1:0]      err_nxt;
  logic                      unused_end;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // The end-of-burst marker carries nothing the beat-by-beat check needs.
  assign unused_end = rd.app_rd_data_end;

  assign exp_data = {{(APP_DATA_WIDTH-8){1'b0}}, exp_addr[7:0]};
  assign mismatch = beat && (rd.app_rd_data != exp_data);
  assign err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_beats == '0) ? ST_DONE : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rd.app_rd_data_valid) begin
          beat = 1'b1;
          // Leave on the beat that completes the run so the result
          // registers land exactly one cycle after it.
          if (beat_cnt + CNT_WIDTH'(1) == num_r) begin
            last_beat = 1'b1;
            state_nxt = ST_DONE;
          end
        end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run status and counters
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      beat_cnt       <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      stray_beat     <= 1'b0;
      idle_cnt       <= '0;
    end else begin
      busy <= (state_nxt == ST_CHECK);
      if (state != ST_CHECK && rd.app_rd_data_valid) stray_beat <= 1'b1;
      if (accept) begin
        err_cnt        <= '0;
        beat_cnt       <= '0;
        timeout        <= 1'b0;
        first_err_addr <= '0;
        first_err_data <= '0;
        idle_cnt       <= '0;
        done           <= (num_beats == '0);
        pass           <= (num_beats == '0);
      end else begin
        if (beat) begin
          beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          err_cnt  <= err_nxt;
          idle_cnt <= '0;
          // A zero count means no mismatch yet in this run; it never
          // returns to zero once incremented because it saturates.
          if (mismatch && err_cnt == '0) begin
            first_err_addr <= exp_addr;
            first_err_data <= rd.app_rd_data[7:0];
          end
        end else if (state == ST_CHECK) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
        if (last_beat) begin
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end
        if (expire) begin
          timeout <= 1'b1;
          done    <= 1'b1;
          pass    <= 1'b0;
        end
      end
    end
  end

  // Run parameters and expected address
  always_ff @(posedge ui_clk) begin
    if (accept) begin
      exp_addr <= base_addr;
      num_r    <= num_beats;
    end else if (beat) begin
      exp_addr <= exp_addr + ADDR_WIDTH'(ADDR_STEP);
    end
  end

endmodule
